note_uart_tx: RTL

NOTE_UART_TX -- requirements
Module: note_uart_tx

---
 rtl/note_uart_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/note_uart_tx.sv
// Turns key-note changes into byte events and sends them as 8N1 UART frames.
// A small FIFO sits between the note encoder and the serialiser so that bursts of key changes are not lost.
module note_uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] note_in,
  input  logic       tx_en,
  output logic       uart_tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       invalid,
  output logic [1:0] state_dbg
);

  localparam int CLKS_RAW     = CLK_FREQ / BAUD;
  localparam int CLKS_PER_BIT = (CLKS_RAW < 2) ? 2 : CLKS_RAW;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W        = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [9:0]         prev_q;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   count_q;
  logic               overflow_q, invalid_q;

  logic [6:0] note_bits;
  logic [2:0] oct_bits;
  logic [3:0] note_idx, oct_code;
  logic [7:0] enc_byte;
  logic       code_valid, note_event, push_req, push, pop, full, bit_end;

  assign note_bits  = note_in[6:0];
  assign oct_bits   = note_in[9:7];
  // A power-of-two test: x & (x-1) is zero only for zero or a single set bit.
  assign code_valid = ((note_bits & (note_bits - 7'd1)) == 7'd0) &&
                      ((oct_bits & (oct_bits - 3'd1)) == 3'd0);

  always_comb begin
    note_idx = 4'd0;
    for (int k = 0; k < 7; k++)
      if (note_bits[k]) note_idx = 4'(k + 1);
    case (oct_bits)
      3'b001:  oct_code = 4'd1;
      3'b010:  oct_code = 4'd2;
      3'b100:  oct_code = 4'd3;
      default: oct_code = 4'd0;
    endcase
    enc_byte = (note_bits == 7'd0) ? 8'h00 : {oct_code, note_idx};
  end

  assign full       = (count_q == OCC_W'(FIFO_DEPTH));
  assign note_event = (note_in != prev_q);
  assign push_req   = note_event && tx_en && code_valid;
  assign push       = push_req && (!full || pop);
  assign bit_end    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        clk_cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else clk_cnt_d = clk_cnt_q + CNT_W'(1);
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else clk_cnt_d = clk_cnt_q + CNT_W'(1);
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else clk_cnt_d = clk_cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      prev_q     <= note_in;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_q + OCC_W'(push) - OCC_W'(pop);
      overflow_q <= push_req && full && !pop;
      invalid_q  <= note_event && tx_en && !code_valid;
    end
  end

  // Storage has no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= enc_byte;
  end

  assign uart_tx   = tx_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign fifo_full = full;
  assign overflow  = overflow_q;
  assign invalid   = invalid_q;
  assign state_dbg = state_q;

endmodule
